collision_scheduler: RTL and testbench
======================================

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, meaning the number of moving-object collider drawing requests.
REQ-002 The block SHALL have parameter NUM_TGT, default 2, meaning the number of target/obstacle drawing requests.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port startOfFrame, input, 1 bit, a one-cycle frame boundary pulse.
REQ-006 The block SHALL have ports pixelX and pixelY, input, 11 bits each, the current VGA pixel aligned with the request inputs.
REQ-007 The block SHALL have port srcReq, input, NUM_SRC bits, the collider drawingRequest vector.
REQ-008 The block SHALL have port tgtReq, input, NUM_TGT bits, the target drawingRequest vector.
REQ-009 The block SHALL have port evtReady, input, 1 bit, the game-logic acknowledge.
REQ-010 The block SHALL have port clearOverflow, input, 1 bit, which clears the sticky overflow flag.
REQ-011 The block SHALL have port evtValid, output, 1 bit, an event presented.
REQ-012 The block SHALL have ports evtSrc, output, clog2(NUM_SRC) bits, and evtTgt, output, clog2(NUM_TGT) bits, the pair identifiers.
REQ-013 The block SHALL have ports evtX and evtY, output, 11 bits each, the first-hit pixel of the presented pair.
REQ-014 The block SHALL have port frameHits, output, NUM_SRC*NUM_TGT bits, the pair bitmap of the last completed frame.
REQ-015 The block SHALL have ports overflow, output, 1 bit, sticky, and busy, output, 1 bit, meaning FSM not IDLE.

Function
REQ-016 Each cycle, pair p = src*NUM_TGT+tgt SHALL be marked hit in the collect bank when srcReq[src] and tgtReq[tgt] are both 1.
REQ-017 Only the first hit of a pair per frame SHALL latch pixelX/pixelY into that pair's collect coordinates; later hits in the same frame SHALL leave them unchanged.
REQ-018 On startOfFrame, the collect bitmap and coordinates SHALL copy into the report bank and frameHits; the collect bank SHALL clear in the same cycle.
REQ-019 A hit coinciding with startOfFrame SHALL be recorded in the new, cleared collect bank.
REQ-020 The FSM SHALL have states IDLE and REPORT; IDLE->REPORT on startOfFrame with a non-zero snapshot; REPORT->IDLE when the report bitmap becomes zero.
REQ-021 In REPORT, evtValid SHALL be 1, with evtSrc/evtTgt/evtX/evtY showing the lowest-index set pair; evtValid SHALL first rise on the cycle after startOfFrame.
REQ-022 Outputs SHALL hold stable while evtValid=1 and evtReady=0.
REQ-023 evtValid=1 and evtReady=1 SHALL clear that pair's bit; the next pair SHALL be presented on the following cycle with no bubble.
REQ-024 startOfFrame in REPORT SHALL replace the report bank with the new snapshot.
REQ-025 In that replacement, overflow SHALL set if any unacknowledged pair remains, where a pair acked in the same cycle counts as delivered.
REQ-026 clearOverflow SHALL clear overflow unless a new overflow occurs in the same cycle, in which case set wins.
REQ-027 busy SHALL equal (state != IDLE); in IDLE, evtValid SHALL be 0.

Reset
REQ-028 On reset, state SHALL go to IDLE and both banks and frameHits SHALL be 0.
REQ-029 On reset, evtValid, evtSrc, evtTgt, evtX, evtY, overflow and busy SHALL all be 0.
REQ-030 Reset SHALL override startOfFrame and an in-flight handshake; a pending event SHALL be dropped without setting overflow.

Structure
REQ-031 Package collision_pkg SHALL hold NUM_SRC/NUM_TGT defaults, the pair-index typedef, the coordinate typedef and the FSM state enum.
REQ-032 Sub-module pair_priority_encoder SHALL return the lowest set index and a valid flag, combinationally, for the report bitmap.
REQ-033 Target implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-034 Src0+tgt1 high at (100,50) and (101,50), then startOfFrame -> next cycle evtValid=1, evtSrc=0, evtTgt=1, evtX=100, evtY=50, and frameHits bit1=1.
REQ-035 Pairs 0,3,5 hit, evtReady tied 1 -> events 0,3,5 on three consecutive cycles, then busy=0.
REQ-036 Pairs 2,4 pending, evtReady=0, new startOfFrame with pair 6 -> overflow=1 and only pair 6 presented; clearOverflow -> overflow=0.
REQ-037 Single pending pair acked in the same cycle as startOfFrame -> overflow stays 0.
REQ-038 Hit on the startOfFrame cycle -> hit absent from the current report and reported after the next startOfFrame.
REQ-039 reset asserted mid-REPORT -> next cycle all outputs 0 and state IDLE; overflow not set.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and default sizing for the collision scheduler.
package collision_pkg;

    // Default counts of collider and target drawing requests.
    localparam int unsigned NUM_SRC_DEF   = 4;
    localparam int unsigned NUM_TGT_DEF   = 2;
    localparam int unsigned NUM_PAIRS_DEF = NUM_SRC_DEF * NUM_TGT_DEF;
    localparam int unsigned PAIR_IDX_W    = (NUM_PAIRS_DEF > 1) ? $clog2(NUM_PAIRS_DEF) : 1;

    // Pair index for the default configuration: p = src*NUM_TGT + tgt.
    typedef logic [PAIR_IDX_W-1:0] pair_idx_t;

    // VGA pixel coordinate.
    typedef logic [10:0] coord_t;

    // Reporting FSM.
    typedef enum logic [0:0] {
        StIdle,
        StReport
    } state_e;

endpackage

// File: rtl/pair_priority_encoder.sv
// Lowest-set-index priority encoder over the report bitmap.
module pair_priority_encoder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] bits,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = |bits;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/collision_scheduler.sv
// Collects per-frame collider/target overlap pairs and replays them as
// handshaked events during the following frame.
module collision_scheduler
    import collision_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DEF,
    parameter int unsigned NUM_TGT = NUM_TGT_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic [10:0]                  pixelX,
    input  logic [10:0]                  pixelY,
    input  logic [NUM_SRC-1:0]           srcReq,
    input  logic [NUM_TGT-1:0]           tgtReq,
    input  logic                         evtReady,
    input  logic                         clearOverflow,
    output logic                         evtValid,
    output logic [$clog2(NUM_SRC)-1:0]   evtSrc,
    output logic [$clog2(NUM_TGT)-1:0]   evtTgt,
    output logic [10:0]                  evtX,
    output logic [10:0]                  evtY,
    output logic [NUM_SRC*NUM_TGT-1:0]   frameHits,
    output logic                         overflow,
    output logic                         busy
);

    localparam int unsigned NUM_PAIRS = NUM_SRC * NUM_TGT;
    localparam int unsigned PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int unsigned SRC_W     = $clog2(NUM_SRC);
    localparam int unsigned TGT_W     = $clog2(NUM_TGT);

    logic [NUM_PAIRS-1:0] hit_vec;
    logic [NUM_PAIRS-1:0] col_hit_q, col_hit_d;
    logic [NUM_PAIRS-1:0] rep_hit_q, rep_hit_d;
    logic [NUM_PAIRS-1:0] ack_mask, rep_remaining;
    logic [NUM_PAIRS-1:0] frame_hits_q;
    coord_t               col_x_q [NUM_PAIRS];
    coord_t               col_y_q [NUM_PAIRS];
    coord_t               col_x_d [NUM_PAIRS];
    coord_t               col_y_d [NUM_PAIRS];
    coord_t               rep_x_q [NUM_PAIRS];
    coord_t               rep_y_q [NUM_PAIRS];
    state_e               state_q, state_d;
    logic                 ovf_q, ovf_d;
    logic [PAIR_W-1:0]    enc_idx;
    logic                 enc_valid;
    logic                 evt_valid;

    // Pairs overlapping on the current pixel.
    always_comb begin
        hit_vec = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int t = 0; t < NUM_TGT; t++) begin
                hit_vec[s*NUM_TGT+t] = srcReq[s] & tgtReq[t];
            end
        end
    end

    // Collect bank: clear on frame start, then record first hits of this cycle.
    always_comb begin
        col_hit_d = col_hit_q;
        col_x_d   = col_x_q;
        col_y_d   = col_y_q;
        if (startOfFrame) begin
            col_hit_d = '0;
            for (int p = 0; p < NUM_PAIRS; p++) begin
                col_x_d[p] = '0;
                col_y_d[p] = '0;
            end
        end
        for (int p = 0; p < NUM_PAIRS; p++) begin
            if (hit_vec[p] && !col_hit_d[p]) begin
                col_hit_d[p] = 1'b1;
                col_x_d[p]   = pixelX;
                col_y_d[p]   = pixelY;
            end
        end
    end

    pair_priority_encoder #(
        .WIDTH (NUM_PAIRS),
        .IDX_W (PAIR_W)
    ) u_enc (
        .bits  (rep_hit_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign evt_valid = (state_q == StReport) && enc_valid;

    // Report bank next state, handshake retirement and overflow detection.
    always_comb begin
        ack_mask = '0;
        if (evt_valid && evtReady) begin
            ack_mask[enc_idx] = 1'b1;
        end
        // A pair acked in the replacement cycle counts as delivered.
        rep_remaining = rep_hit_q & ~ack_mask;
        rep_hit_d     = startOfFrame ? col_hit_q : rep_remaining;

        ovf_d = ovf_q;
        if (clearOverflow) begin
            ovf_d = 1'b0;
        end
        if (startOfFrame && (|rep_remaining)) begin
            ovf_d = 1'b1;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (startOfFrame && (|col_hit_q)) begin
                    state_d = StReport;
                end
            end
            StReport: begin
                if (rep_hit_d == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, bank and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            col_hit_q    <= '0;
            rep_hit_q    <= '0;
            frame_hits_q <= '0;
            ovf_q        <= 1'b0;
            for (int p = 0; p < NUM_PAIRS; p++) begin
                col_x_q[p] <= '0;
                col_y_q[p] <= '0;
                rep_x_q[p] <= '0;
                rep_y_q[p] <= '0;
            end
        end else begin
            state_q   <= state_d;
            col_hit_q <= col_hit_d;
            col_x_q   <= col_x_d;
            col_y_q   <= col_y_d;
            rep_hit_q <= rep_hit_d;
            ovf_q     <= ovf_d;
            if (startOfFrame) begin
                frame_hits_q <= col_hit_q;
                rep_x_q      <= col_x_q;
                rep_y_q      <= col_y_q;
            end
        end
    end

    // Event outputs are zero whenever nothing is presented.
    always_comb begin
        evtValid  = evt_valid;
        evtSrc    = '0;
        evtTgt    = '0;
        evtX      = '0;
        evtY      = '0;
        if (evt_valid) begin
            evtSrc = SRC_W'(32'(enc_idx) / NUM_TGT);
            evtTgt = TGT_W'(32'(enc_idx) % NUM_TGT);
            evtX   = rep_x_q[enc_idx];
            evtY   = rep_y_q[enc_idx];
        end
        frameHits = frame_hits_q;
        overflow  = ovf_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_collision_scheduler.sv
// Randomized and directed bench for collision_scheduler against a
// frame-level reference model.
module tb_collision_scheduler;

    localparam int NS = 4;
    localparam int NT = 2;
    localparam int NP = NS * NT;

    logic          clk = 1'b0;
    logic          reset;
    logic          startOfFrame;
    logic [10:0]   pixelX, pixelY;
    logic [NS-1:0] srcReq;
    logic [NT-1:0] tgtReq;
    logic          evtReady, clearOverflow;
    logic          evtValid;
    logic [1:0]    evtSrc;
    logic [0:0]    evtTgt;
    logic [10:0]   evtX, evtY;
    logic [NP-1:0] frameHits;
    logic          overflow, busy;

    int total = 0;
    int bad   = 0;

    // Reference model: collect set, report set, snapshot bitmap, sticky flag.
    bit          m_col [NP];
    int          m_cx  [NP];
    int          m_cy  [NP];
    bit          m_rep [NP];
    int          m_rx  [NP];
    int          m_ry  [NP];
    bit [NP-1:0] m_frame;
    bit          m_ovf;

    collision_scheduler #(
        .NUM_SRC (NS),
        .NUM_TGT (NT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .pixelX        (pixelX),
        .pixelY        (pixelY),
        .srcReq        (srcReq),
        .tgtReq        (tgtReq),
        .evtReady      (evtReady),
        .clearOverflow (clearOverflow),
        .evtValid      (evtValid),
        .evtSrc        (evtSrc),
        .evtTgt        (evtTgt),
        .evtX          (evtX),
        .evtY          (evtY),
        .frameHits     (frameHits),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_first();
        for (int p = 0; p < NP; p++) begin
            if (m_rep[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_col[p] = 0; m_cx[p] = 0; m_cy[p] = 0;
            m_rep[p] = 0; m_rx[p] = 0; m_ry[p] = 0;
        end
        m_frame = '0;
        m_ovf   = 0;
    endtask

    task automatic check_outputs();
        int f;
        f = m_first();
        check_val("busy", busy, (f >= 0));
        check_val("evtValid", evtValid, (f >= 0));
        check_val("evtSrc", evtSrc, (f >= 0) ? f / NT : 0);
        check_val("evtTgt", evtTgt, (f >= 0) ? f % NT : 0);
        check_val("evtX", evtX, (f >= 0) ? m_rx[f] : 0);
        check_val("evtY", evtY, (f >= 0) ? m_ry[f] : 0);
        check_val("frameHits", frameHits, m_frame);
        check_val("overflow", overflow, m_ovf);
    endtask

    // Advance the model by one clock given the inputs held this cycle.
    task automatic model_clock(input bit sof, input logic [NS-1:0] s, input logic [NT-1:0] t,
                               input int px, input int py, input bit rdy, input bit clr,
                               input bit rst);
        int  f;
        bit  left;
        if (rst) begin
            model_reset();
            return;
        end
        f = m_first();
        if (f >= 0 && rdy) m_rep[f] = 0;
        if (clr) m_ovf = 0;
        if (sof) begin
            left = 0;
            for (int p = 0; p < NP; p++) left |= m_rep[p];
            if (left) m_ovf = 1;
            for (int p = 0; p < NP; p++) begin
                m_rep[p]   = m_col[p];
                m_rx[p]    = m_cx[p];
                m_ry[p]    = m_cy[p];
                m_frame[p] = m_col[p];
                m_col[p]   = 0;
            end
        end
        for (int a = 0; a < NS; a++) begin
            for (int b = 0; b < NT; b++) begin
                if (s[a] && t[b] && !m_col[a*NT+b]) begin
                    m_col[a*NT+b] = 1;
                    m_cx[a*NT+b]  = px;
                    m_cy[a*NT+b]  = py;
                end
            end
        end
    endtask

    // One cycle: drive after the falling edge, check, update model; rising edge follows.
    task automatic step(input bit sof, input logic [NS-1:0] s, input logic [NT-1:0] t,
                        input int px, input int py, input bit rdy, input bit clr, input bit rst);
        @(negedge clk);
        startOfFrame  = sof;
        srcReq        = s;
        tgtReq        = t;
        pixelX        = 11'(px);
        pixelY        = 11'(py);
        evtReady      = rdy;
        clearOverflow = clr;
        reset         = rst;
        #2;
        check_outputs();
        model_clock(sof, s, t, px, py, rdy, clr, rst);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; srcReq = '0; tgtReq = '0;
        pixelX = '0; pixelY = '0; evtReady = 1'b0; clearOverflow = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);

        // Pair 1 hit twice; only the first pixel is kept.
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        step(0, 4'b0001, 2'b10, 100, 50, 0, 0, 0);
        step(0, 4'b0001, 2'b10, 101, 50, 0, 0, 0);
        step(1, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        check_val("first_hit_valid", evtValid, 1);
        check_val("first_hit_src", evtSrc, 0);
        check_val("first_hit_tgt", evtTgt, 1);
        check_val("first_hit_x", evtX, 100);
        check_val("first_hit_y", evtY, 50);
        check_val("first_hit_frame", frameHits, 8'b0000_0010);

        // Pairs 0,3,5 drained back-to-back with ready held high.
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        step(0, 4'b0001, 2'b01, 7, 8, 1, 0, 0);
        step(0, 4'b0110, 2'b10, 9, 10, 1, 0, 0);
        step(1, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
        step(0, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
        check_val("drain_first_src", evtSrc, 0);
        step(0, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
        step(0, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
        check_val("drain_last_src", evtSrc, 2);
        step(0, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
        check_val("drain_idle_busy", busy, 0);

        // Pairs 2,4 left unacked when pair 6 arrives: overflow, then clear.
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        step(0, 4'b0110, 2'b01, 20, 21, 0, 0, 0);
        step(1, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        step(0, 4'b1000, 2'b01, 30, 31, 0, 0, 0);
        step(1, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        check_val("ovf_set", overflow, 1);
        check_val("ovf_only_pair6_src", evtSrc, 3);
        step(0, 4'b0000, 2'b00, 0, 0, 1, 1, 0);
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        check_val("ovf_cleared", overflow, 0);

        // Last pending pair acked on the frame boundary: no overflow.
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        step(0, 4'b0001, 2'b10, 5, 6, 0, 0, 0);
        step(1, 4'b0010, 2'b01, 0, 0, 0, 0, 0);
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        step(1, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        check_val("ack_on_sof_ovf", overflow, 0);

        // Hit on the boundary cycle belongs to the next frame.
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        step(1, 4'b1000, 2'b10, 44, 55, 0, 0, 0);
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        check_val("sof_hit_deferred", evtValid, 0);
        step(1, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        check_val("sof_hit_later_x", evtX, 44);

        // Reset while reporting drops events without overflow.
        step(1, 4'b0000, 2'b00, 0, 0, 1, 0, 1);
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        check_val("rst_mid_report_busy", busy, 0);
        check_val("rst_mid_report_ovf", overflow, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 15) == 0),
                 NS'($urandom & $urandom), NT'($urandom),
                 int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 299) == 0));
        end
        step(0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
